reg_scoreboard: RTL and testbench

Issue-side hazard controller for the two-read/one-write register file. It tracks which architectural registers have writes still in flight and accepts an instruction only when its source operands can be read correctly and its destination is free. On acceptance it drives the register file read ports, and one cycle later it flags the read data as valid. It sits between decode and the register file and observes the same writeback bus that drives the register file write port.

---
 rtl/reg_scoreboard_if.sv | 39 +++
 rtl/reg_scoreboard.sv | 80 ++++++++
 tb/tb_reg_scoreboard.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue, register-file read, writeback and status signals of the register scoreboard.
// Decode, the register file and the writeback bus sit on the master side.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_used;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_used;

    logic        rf_read1_valid;
    logic        rf_read2_valid;
    logic [4:0]  rf_read1_addr;
    logic [4:0]  rf_read2_addr;
    logic        opnd_valid;

    logic        wb_valid;
    logic [4:0]  wb_addr;

    logic [31:0] busy;
    logic [4:0]  inflight_count;
    logic        wb_error;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_used, wb_valid, wb_addr,
        input  issue_ready, rf_read1_valid, rf_read2_valid, rf_read1_addr,
               rf_read2_addr, opnd_valid, busy, inflight_count, wb_error
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_used, wb_valid, wb_addr,
        output issue_ready, rf_read1_valid, rf_read2_valid, rf_read1_addr,
               rf_read2_addr, opnd_valid, busy, inflight_count, wb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller: tracks registers with writes in flight, gates issue on
// RAW/WAW/capacity hazards, drives register-file reads and flags operand data a cycle later.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input logic            clock,
    input logic            reset,
    reg_scoreboard_if.slave sb
);
    localparam logic [4:0] MAX_CNT = 5'(MAX_INFLIGHT);

    logic [31:0] busy_q, busy_d;
    logic [4:0]  count_q, count_d;
    logic        opnd_valid_q, opnd_valid_d;
    logic        wb_error_q, wb_error_d;

    logic wb_clr, raw1, raw2, rd_live, waw, cap_stall, ready, fire, set_busy;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        busy_d       = busy_q;
        count_d      = count_q;
        wb_error_d   = wb_error_q;

        // A writeback that retires a busy register releases it in this very cycle.
        wb_clr    = sb.wb_valid && (sb.wb_addr != 5'd0) && busy_q[sb.wb_addr];
        raw1      = sb.issue_rs1_used && (sb.issue_rs1 != 5'd0) && busy_q[sb.issue_rs1]
                    && !(wb_clr && (sb.wb_addr == sb.issue_rs1));
        raw2      = sb.issue_rs2_used && (sb.issue_rs2 != 5'd0) && busy_q[sb.issue_rs2]
                    && !(wb_clr && (sb.wb_addr == sb.issue_rs2));
        rd_live   = sb.issue_rd_used && (sb.issue_rd != 5'd0);
        waw       = rd_live && busy_q[sb.issue_rd] && !(wb_clr && (sb.wb_addr == sb.issue_rd));
        cap_stall = rd_live && (count_q == MAX_CNT) && !wb_clr;

        ready     = !reset && !raw1 && !raw2 && !waw && !cap_stall;
        fire      = sb.issue_valid && ready;
        set_busy  = fire && rd_live;

        // Clear before set so a same-register set and clear leaves the bit busy.
        if (wb_clr)   busy_d[sb.wb_addr]  = 1'b0;
        if (set_busy) busy_d[sb.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        case ({set_busy, wb_clr})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (sb.wb_valid && ((sb.wb_addr == 5'd0) || !busy_q[sb.wb_addr]))
            wb_error_d = 1'b1;

        opnd_valid_d = fire;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            busy_q       <= '0;
            count_q      <= '0;
            opnd_valid_q <= 1'b0;
            wb_error_q   <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            count_q      <= count_d;
            opnd_valid_q <= opnd_valid_d;
            wb_error_q   <= wb_error_d;
        end
    end

    assign sb.issue_ready    = ready;
    assign sb.rf_read1_valid = fire && sb.issue_rs1_used;
    assign sb.rf_read2_valid = fire && sb.issue_rs2_used;
    assign sb.rf_read1_addr  = (fire && sb.issue_rs1_used) ? sb.issue_rs1 : 5'd0;
    assign sb.rf_read2_addr  = (fire && sb.issue_rs2_used) ? sb.issue_rs2 : 5'd0;
    assign sb.opnd_valid     = opnd_valid_q;
    assign sb.busy           = busy_q;
    assign sb.inflight_count = count_q;
    assign sb.wb_error       = wb_error_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard with a set-based hazard model, a
// forwarding register file stand-in and a scoreboard queue for operand read responses.
module tb_reg_scoreboard;
    localparam int MAXI = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reg_scoreboard_if sb();

    reg_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } rsp_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    rsp_t        exp_q[$];
    bit          pending[int];
    bit          m_err  = 1'b0;
    bit          m_opnd = 1'b0;
    logic [31:0] wb_data = '0;
    logic [31:0] mem [32];
    logic [31:0] rd1_q, rd2_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file with write-to-read forwarding; x0 always reads zero.
    function automatic logic [31:0] fwd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (sb.wb_valid && sb.wb_addr == a) return wb_data;
        return mem[a];
    endfunction

    always @(posedge clock) begin
        rd1_q <= sb.rf_read1_valid ? fwd(sb.rf_read1_addr) : 32'd0;
        rd2_q <= sb.rf_read2_valid ? fwd(sb.rf_read2_addr) : 32'd0;
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'd0 : (32'hA500_0000 | 32'(i));
        end else if (sb.wb_valid && sb.wb_addr != 5'd0) begin
            mem[sb.wb_addr] <= wb_data;
        end
    end

    always @(negedge clock) begin
        if (sb.opnd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL opnd_unexpected: got opnd_valid=1, want no pending response (t=%0t)", $time);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("read1_data", rd1_q, e.d1);
                check("read2_data", rd2_q, e.d2);
            end
        end
    end

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (pending[k]) b[k] = 1'b1;
        return b;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle(input bit rst, input bit v,
                         input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit rdu,
                         input bit wbv, input logic [4:0] wba);
        bit wbclr, raw1, raw2, waw, cap, rdy, fire;
        @(posedge clock);
        #1;
        reset             = rst;
        sb.issue_valid    = v;
        sb.issue_rs1      = rs1;
        sb.issue_rs1_used = u1;
        sb.issue_rs2      = rs2;
        sb.issue_rs2_used = u2;
        sb.issue_rd       = rd;
        sb.issue_rd_used  = rdu;
        sb.wb_valid       = wbv;
        sb.wb_addr        = wba;
        wb_data           = $urandom;
        #3;
        check("busy", sb.busy, model_busy());
        check("inflight_count", 32'(sb.inflight_count), 32'(pending.num()));
        check("wb_error", 32'(sb.wb_error), 32'(m_err));
        check("opnd_valid", 32'(sb.opnd_valid), 32'(m_opnd));

        wbclr = wbv && wba != 0 && pending.exists(int'(wba));
        raw1  = u1 && rs1 != 0 && pending.exists(int'(rs1)) && !(wbclr && wba == rs1);
        raw2  = u2 && rs2 != 0 && pending.exists(int'(rs2)) && !(wbclr && wba == rs2);
        waw   = rdu && rd != 0 && pending.exists(int'(rd)) && !(wbclr && wba == rd);
        cap   = rdu && rd != 0 && pending.num() == MAXI && !wbclr;
        rdy   = !rst && !raw1 && !raw2 && !waw && !cap;
        fire  = v && rdy;

        check("issue_ready", 32'(sb.issue_ready), 32'(rdy));
        check("rf_read1", {26'd0, sb.rf_read1_valid, sb.rf_read1_addr},
              {26'd0, fire && u1, (fire && u1) ? rs1 : 5'd0});
        check("rf_read2", {26'd0, sb.rf_read2_valid, sb.rf_read2_addr},
              {26'd0, fire && u2, (fire && u2) ? rs2 : 5'd0});
        if (fire) exp_q.push_back('{u1 ? fwd(rs1) : 32'd0, u2 ? fwd(rs2) : 32'd0});

        if (rst) begin
            pending.delete();
            m_err  = 1'b0;
            m_opnd = 1'b0;
        end else begin
            if (wbv && (wba == 0 || !pending.exists(int'(wba)))) m_err = 1'b1;
            if (wbclr) pending.delete(int'(wba));
            if (fire && rdu && rd != 0) pending[int'(rd)] = 1'b1;
            m_opnd = fire;
        end
    endtask

    task automatic iss(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit rdu, input bit wbv, input logic [4:0] wba);
        cycle(1'b0, 1'b1, rs1, u1, rs2, u2, rd, rdu, wbv, wba);
    endtask

    task automatic nop(input bit wbv, input logic [4:0] wba);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, wbv, wba);
    endtask

    initial begin
        sb.issue_valid = 1'b0; sb.issue_rs1 = '0; sb.issue_rs2 = '0; sb.issue_rs1_used = 1'b0;
        sb.issue_rs2_used = 1'b0; sb.issue_rd = '0; sb.issue_rd_used = 1'b0;
        sb.wb_valid = 1'b0; sb.wb_addr = '0;
        cycle(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);

        // Independent stream rd=1,2,3.
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 5'd0);
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0);
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
        nop(1'b0, 5'd0);
        check("stream_busy", sb.busy, 32'h0000_000E);
        check("stream_count", 32'(sb.inflight_count), 32'd3);

        // RAW stall on x5, released by same-cycle writeback with forwarded data.
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0);
        iss(5'd5, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        check("raw_stall", 32'(sb.issue_ready), 32'd0);
        iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        iss(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
        check("raw_release", 32'(sb.issue_ready), 32'd1);
        nop(1'b0, 5'd0);

        // WAW on x7 with simultaneous writeback of x7.
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0);
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7);
        check("waw_fire", 32'(sb.issue_ready), 32'd1);
        nop(1'b0, 5'd0);
        check("waw_busy7", 32'(sb.busy[7]), 32'd1);
        check("waw_count", 32'(sb.inflight_count), 32'd4);

        // Capacity: {1,2,3,7} busy.
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0);
        check("cap_stall", 32'(sb.issue_ready), 32'd0);
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd1);
        check("cap_wb_fire", 32'(sb.issue_ready), 32'd1);
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        check("cap_rd0_fire", 32'(sb.issue_ready), 32'd1);
        check("cap_count", 32'(sb.inflight_count), 32'd4);

        // x0 handling.
        iss(5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
        check("x0_ready", 32'(sb.issue_ready), 32'd1);
        check("x0_addr", 32'(sb.rf_read1_addr), 32'd0);
        nop(1'b1, 5'd0);
        nop(1'b0, 5'd0);
        check("x0_wb_error", 32'(sb.wb_error), 32'd1);

        // Reset mid-operation, then a stale writeback.
        iss(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 5'd2);
        cycle(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0);
        nop(1'b1, 5'd3);
        check("rst_busy", sb.busy, 32'd0);
        check("rst_count", 32'(sb.inflight_count), 32'd0);
        check("rst_opnd", 32'(sb.opnd_valid), 32'd0);
        nop(1'b0, 5'd0);
        check("rst_stale_wb", 32'(sb.wb_error), 32'd1);

        // Randomized traffic; small register range keeps hazards frequent.
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        for (int n = 0; n < 600; n++) begin
            int          keys[$];
            logic [4:0]  wba;
            bit          wbv;
            foreach (pending[k]) keys.push_back(k);
            wbv = 1'b0;
            wba = 5'd0;
            if (keys.size() != 0 && $urandom_range(0, 99) < 45) begin
                wbv = 1'b1;
                wba = 5'(keys[$urandom_range(0, keys.size() - 1)]);
            end else if ($urandom_range(0, 99) < 3) begin
                wbv = 1'b1;
                wba = 5'($urandom_range(0, 31));
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 80,
                  5'($urandom_range(0, 11)), 1'($urandom), 5'($urandom_range(0, 11)), 1'($urandom),
                  5'($urandom_range(0, 11)), $urandom_range(0, 99) < 75, wbv, wba);
        end

        for (int n = 0; n < 3; n++) nop(1'b0, 5'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
